// File: rtl/addsub_arbiter_if.sv
// rtl/addsub_arbiter_if.sv - request/grant and result channel bundle for the add/sub arbiter
interface addsub_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             iReq0;
  logic [WIDTH-1:0] iA0;
  logic [WIDTH-1:0] iB0;
  logic             iMode0;
  logic             oGnt0;

  logic             iReq1;
  logic [WIDTH-1:0] iA1;
  logic [WIDTH-1:0] iB1;
  logic             iMode1;
  logic             oGnt1;

  logic             oValid;
  logic             iReady;
  logic [WIDTH-1:0] oSum;
  logic             oCarry;
  logic             oId;
  logic             oBusy;

  modport master (
    output iReq0, iA0, iB0, iMode0,
    output iReq1, iA1, iB1, iMode1,
    output iReady,
    input  oGnt0, oGnt1, oValid, oSum, oCarry, oId, oBusy
  );

  modport slave (
    input  iReq0, iA0, iB0, iMode0,
    input  iReq1, iA1, iB1, iMode1,
    input  iReady,
    output oGnt0, oGnt1, oValid, oSum, oCarry, oId, oBusy
  );
endinterface

// File: rtl/addsub_arbiter.sv
// rtl/addsub_arbiter.sv - two-requester round-robin arbiter in front of one add/sub unit
module addsub_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic              iClk,
  input  logic              iRst,
  addsub_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic             r_ptr, w_ptr_nxt;
  logic             r_win, w_win_nxt;
  logic [WIDTH-1:0] r_a, w_a_nxt;
  logic [WIDTH-1:0] r_b, w_b_nxt;
  logic             r_mode, w_mode_nxt;

  logic             r_gnt0, w_gnt0_nxt;
  logic             r_gnt1, w_gnt1_nxt;
  logic             r_valid, w_valid_nxt;
  logic [WIDTH-1:0] r_sum, w_sum_nxt;
  logic             r_carry, w_carry_nxt;
  logic             r_id, w_id_nxt;
  logic             r_busy, w_busy_nxt;

  logic [WIDTH:0]   w_result;
  logic             w_any_req;
  logic             w_pick;

  // Zero-extended subtraction leaves the borrow in the extra MSB.
  always_comb begin
    if (r_mode)
      w_result = {1'b0, r_a} - {1'b0, r_b};
    else
      w_result = {1'b0, r_a} + {1'b0, r_b};
  end

  assign w_any_req = bus.iReq0 | bus.iReq1;
  assign w_pick    = (bus.iReq0 && bus.iReq1) ? r_ptr : bus.iReq1;

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_win_nxt   = r_win;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_mode_nxt  = r_mode;
    w_gnt0_nxt  = 1'b0;
    w_gnt1_nxt  = 1'b0;
    w_valid_nxt = r_valid;
    w_sum_nxt   = r_sum;
    w_carry_nxt = r_carry;
    w_id_nxt    = r_id;
    w_busy_nxt  = r_busy;

    unique case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_win_nxt   = w_pick;
          w_a_nxt     = w_pick ? bus.iA1 : bus.iA0;
          w_b_nxt     = w_pick ? bus.iB1 : bus.iB0;
          w_mode_nxt  = w_pick ? bus.iMode1 : bus.iMode0;
          w_gnt0_nxt  = ~w_pick;
          w_gnt1_nxt  = w_pick;
          w_busy_nxt  = 1'b1;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        w_sum_nxt   = w_result[WIDTH-1:0];
        w_carry_nxt = w_result[WIDTH];
        w_id_nxt    = r_win;
        w_valid_nxt = 1'b1;
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        // Priority flips only when the result actually leaves.
        if (r_valid && bus.iReady) begin
          w_valid_nxt = 1'b0;
          w_busy_nxt  = 1'b0;
          w_ptr_nxt   = ~r_win;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state <= S_IDLE;
      r_ptr   <= 1'b0;
      r_win   <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_mode  <= 1'b0;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_valid <= 1'b0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_id    <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_win   <= w_win_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_mode  <= w_mode_nxt;
      r_gnt0  <= w_gnt0_nxt;
      r_gnt1  <= w_gnt1_nxt;
      r_valid <= w_valid_nxt;
      r_sum   <= w_sum_nxt;
      r_carry <= w_carry_nxt;
      r_id    <= w_id_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign bus.oGnt0  = r_gnt0;
  assign bus.oGnt1  = r_gnt1;
  assign bus.oValid = r_valid;
  assign bus.oSum   = r_sum;
  assign bus.oCarry = r_carry;
  assign bus.oId    = r_id;
  assign bus.oBusy  = r_busy;

endmodule

// File: tb/tb_addsub_arbiter.sv
// tb/tb_addsub_arbiter.sv - randomized and directed checks against a transaction-level model
module tb_addsub_arbiter;

  logic clk;
  logic rst;

  addsub_arbiter_if #(.WIDTH(8)) bus ();

  addsub_arbiter #(.WIDTH(8)) dut (
    .iClk (clk),
    .iRst (rst),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: one job in flight, timed by the edge number of its grant.
  int       edge_no = 0;
  bit       m_busy  = 0;
  int       m_g     = 0;
  bit       m_win   = 0;
  bit       m_ptr   = 0;
  int       m_res   = 0;
  bit       exp_gnt0 = 0;
  bit       exp_gnt1 = 0;
  bit       exp_valid = 0;
  bit [7:0] exp_sum = 0;
  bit       exp_carry = 0;
  bit       exp_id = 0;
  bit       acc_ids[$];
  int       acc_sums[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    int a, b;
    bit mode;
    if (rst) begin
      m_busy = 0; m_ptr = 0; m_win = 0;
      exp_gnt0 = 0; exp_gnt1 = 0; exp_valid = 0;
      exp_sum = 0; exp_carry = 0; exp_id = 0;
    end else begin
      exp_gnt0 = 0;
      exp_gnt1 = 0;
      if (!m_busy) begin
        if (bus.iReq0 || bus.iReq1) begin
          m_win = (bus.iReq0 && bus.iReq1) ? m_ptr : bus.iReq1;
          a    = m_win ? int'(bus.iA1) : int'(bus.iA0);
          b    = m_win ? int'(bus.iB1) : int'(bus.iB0);
          mode = m_win ? bus.iMode1 : bus.iMode0;
          m_res = mode ? ((a - b) & 'h1FF) : (a + b);
          m_busy = 1;
          m_g = edge_no;
          if (m_win) exp_gnt1 = 1; else exp_gnt0 = 1;
        end
      end else if (edge_no == m_g + 1) begin
        exp_valid = 1;
        exp_sum   = m_res[7:0];
        exp_carry = m_res[8];
        exp_id    = m_win;
      end else if (bus.iReady) begin
        exp_valid = 0;
        m_busy = 0;
        m_ptr = !m_win;
        acc_ids.push_back(m_win);
        acc_sums.push_back(m_res);
      end
    end
    edge_no++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("gnt0",  32'(bus.oGnt0),  32'(exp_gnt0));
    chk("gnt1",  32'(bus.oGnt1),  32'(exp_gnt1));
    chk("valid", 32'(bus.oValid), 32'(exp_valid));
    chk("sum",   32'(bus.oSum),   32'(exp_sum));
    chk("carry", 32'(bus.oCarry), 32'(exp_carry));
    chk("id",    32'(bus.oId),    32'(exp_id));
    chk("busy",  32'(bus.oBusy),  32'(m_busy));
  endtask

  task automatic drain();
    bus.iReq0 = 0;
    bus.iReq1 = 0;
    bus.iReady = 1;
    for (int i = 0; i < 10 && m_busy; i++) step();
    chk("drain_idle", 32'(m_busy), 32'd0);
  endtask

  task automatic op0(input logic [7:0] a, input logic [7:0] b, input logic mode,
                     input logic [7:0] es, input logic ec, input string tag);
    bus.iReq0 = 1; bus.iA0 = a; bus.iB0 = b; bus.iMode0 = mode; bus.iReady = 1;
    step();
    chk({tag, "_gnt0"}, 32'(bus.oGnt0), 32'd1);
    bus.iReq0 = 0;
    step();
    chk({tag, "_valid"}, 32'(bus.oValid), 32'd1);
    chk({tag, "_sum"},   32'(bus.oSum),   32'(es));
    chk({tag, "_carry"}, 32'(bus.oCarry), 32'(ec));
    chk({tag, "_id"},    32'(bus.oId),    32'd0);
    step();
    chk({tag, "_busy"},  32'(bus.oBusy),  32'd0);
  endtask

  initial begin
    rst = 1;
    bus.iReq0 = 0; bus.iA0 = 0; bus.iB0 = 0; bus.iMode0 = 0;
    bus.iReq1 = 0; bus.iA1 = 0; bus.iB1 = 0; bus.iMode1 = 0;
    bus.iReady = 0;
    step();
    step();
    chk("rst_valid", 32'(bus.oValid), 32'd0);
    chk("rst_busy",  32'(bus.oBusy),  32'd0);
    rst = 0;
    step();

    // Single ADD and carry/borrow corners.
    op0(8'h05, 8'h03, 1'b0, 8'h08, 1'b0, "t1_add");
    op0(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "t2_ovf");
    op0(8'h03, 8'h05, 1'b1, 8'hFE, 1'b1, "t2_borrow");
    op0(8'h05, 8'h03, 1'b1, 8'h02, 1'b0, "t2_sub");
    op0(8'h80, 8'h80, 1'b1, 8'h00, 1'b0, "t2_zero");

    // Round-robin with both requests held from reset.
    rst = 1;
    bus.iReq0 = 1; bus.iA0 = 8'h10; bus.iB0 = 8'h01; bus.iMode0 = 0;
    bus.iReq1 = 1; bus.iA1 = 8'h20; bus.iB1 = 8'h01; bus.iMode1 = 1;
    bus.iReady = 1;
    step();
    rst = 0;
    acc_ids.delete();
    acc_sums.delete();
    repeat (12) step();
    drain();
    chk("rr_count", 32'(acc_ids.size()), 32'd4);
    if (acc_ids.size() >= 4) begin
      chk("rr_id0", 32'(acc_ids[0]), 32'd0);
      chk("rr_id1", 32'(acc_ids[1]), 32'd1);
      chk("rr_id2", 32'(acc_ids[2]), 32'd0);
      chk("rr_id3", 32'(acc_ids[3]), 32'd1);
      chk("rr_sum0", 32'(acc_sums[0]), 32'h11);
      chk("rr_sum1", 32'(acc_sums[1]), 32'h1F);
    end

    // Backpressure with requester 1 waiting.
    bus.iReq0 = 1; bus.iA0 = 8'h05; bus.iB0 = 8'h03; bus.iMode0 = 0;
    bus.iReq1 = 1; bus.iA1 = 8'h20; bus.iB1 = 8'h01; bus.iMode1 = 1;
    bus.iReady = 0;
    step();
    chk("bp_gnt0", 32'(bus.oGnt0), 32'd1);
    bus.iReq0 = 0;
    step();
    repeat (5) begin
      step();
      chk("bp_hold_valid", 32'(bus.oValid), 32'd1);
      chk("bp_hold_sum",   32'(bus.oSum),   32'h08);
      chk("bp_no_gnt1",    32'(bus.oGnt1),  32'd0);
    end
    bus.iReady = 1;
    step();
    chk("bp_accept", 32'(bus.oValid), 32'd0);
    step();
    chk("bp_gnt1", 32'(bus.oGnt1), 32'd1);
    drain();

    // Operands captured only on the grant edge.
    bus.iReq0 = 1; bus.iA0 = 8'h05; bus.iB0 = 8'h03; bus.iMode0 = 0;
    step();
    bus.iReq0 = 0; bus.iA0 = 8'hAA; bus.iB0 = 8'h77; bus.iMode0 = 1;
    step();
    chk("oh_sum", 32'(bus.oSum), 32'h08);
    drain();

    // Reset while in EXEC, request held through it.
    bus.iReq0 = 1; bus.iA0 = 8'h40; bus.iB0 = 8'h02; bus.iMode0 = 0;
    step();
    rst = 1;
    step();
    chk("rm_valid", 32'(bus.oValid), 32'd0);
    chk("rm_busy",  32'(bus.oBusy),  32'd0);
    chk("rm_gnt0",  32'(bus.oGnt0),  32'd0);
    rst = 0;
    step();
    chk("rm_regrant", 32'(bus.oGnt0), 32'd1);
    drain();

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 79) == 0);
      if (bus.iReq0 && exp_gnt0) begin
        if ($urandom_range(0, 1) == 0) bus.iReq0 = 0;
        bus.iA0 = 8'($urandom); bus.iB0 = 8'($urandom); bus.iMode0 = 1'($urandom);
      end else if (!bus.iReq0 && $urandom_range(0, 2) == 0) begin
        bus.iReq0 = 1;
        bus.iA0 = 8'($urandom); bus.iB0 = 8'($urandom); bus.iMode0 = 1'($urandom);
      end
      if (bus.iReq1 && exp_gnt1) begin
        if ($urandom_range(0, 1) == 0) bus.iReq1 = 0;
        bus.iA1 = 8'($urandom); bus.iB1 = 8'($urandom); bus.iMode1 = 1'($urandom);
      end else if (!bus.iReq1 && $urandom_range(0, 2) == 0) begin
        bus.iReq1 = 1;
        bus.iA1 = 8'($urandom); bus.iB1 = 8'($urandom); bus.iMode1 = 1'($urandom);
      end
      bus.iReady = ($urandom_range(0, 3) != 0);
      step();
    end
    rst = 0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/addsub_arbiter.md
Name: addsub_arbiter

Overview:
Two-requester round-robin arbiter and sequencer for a shared 8-bit add/sub datapath. Each requester presents its operands and mode. The block grants one requester, latches that requester's operands, and computes {carry, sum} in one cycle. The result is held on a valid/ready output channel tagged with the requester ID. It sits between two client blocks (e.g. UART command decoder, button/FND front-end) and the single add/sub resource on Basys3.

Parameters:
WIDTH, 8, operand/result width in bits; carry is the extra MSB of a WIDTH+1-bit result.

Ports:
iClk  in  1  system clock; all state changes on the rising edge
iRst  in  1  synchronous reset, active-high
iReq0  in  1  requester 0 request, level; held until oGnt0 is seen
iA0  in  WIDTH  requester 0 operand A
iB0  in  WIDTH  requester 0 operand B
iMode0  in  1  requester 0 op: 0 = ADD, 1 = SUB
oGnt0  out  1  one-cycle pulse: requester 0 operands captured
iReq1  in  1  requester 1 request, level
iA1  in  WIDTH  requester 1 operand A
iB1  in  WIDTH  requester 1 operand B
iMode1  in  1  requester 1 op
oGnt1  out  1  one-cycle pulse: requester 1 operands captured
oValid  out  1  result valid
iReady  in  1  downstream accepts result when oValid && iReady
oSum  out  WIDTH  result
oCarry  out  1  ADD: carry-out; SUB: borrow (1 when A < B unsigned)
oId  out  1  requester that owns the current result
oBusy  out  1  high whenever FSM is not IDLE

Behaviour:
- One clock, iClk. Reset is synchronous and active-high on iRst.
- All outputs are registered.
- Reset values: oGnt0/1=0, oValid=0, oSum=0, oCarry=0, oId=0, oBusy=0, state=IDLE, priority pointer=0, operand registers=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: pick that requester.
  - Both requesting: pick the requester selected by the priority pointer.
  - On the selecting edge: latch A/B/mode and the winner ID, set oGnt<winner>=1 for exactly one cycle, oBusy=1, go to EXEC.
- EXEC:
  - Compute in WIDTH+1 bits. ADD: {c,s}=A+B. SUB: {c,s}=A-B, two's complement, so c is the borrow.
  - On the edge: load oSum/oCarry, oId=winner, oValid=1, clear oGnt, go to RESP.
- RESP:
  - oValid, oSum, oCarry and oId are held stable until oValid && iReady at an edge.
  - On that edge: oValid=0, oBusy=0, pointer=~winner, go to IDLE.
  - iReady is ignored outside RESP.
- Latency: request high before edge 0 -> oGnt high in cycle 1 -> oValid high from cycle 2. Minimum issue interval is 3 cycles with iReady tied high.
- Requests arriving while not in IDLE are not granted; they wait as level requests.
- A requester still asserting iReq after its grant is treated as a new request.
- Operands are sampled only on the grant edge. Later changes to iA/iB/iMode do not affect the in-flight result.
- Round-robin: the pointer only changes on result acceptance. After reset, both requesting -> order is 0, 1, 0, 1, ...
- No combinational path from any input to any output.
- Reset mid-operation (EXEC or RESP):
  - The in-flight op is discarded and all registers take reset values on that edge.
  - No grant or valid is issued for the discarded op.
  - Requests still high after reset release are arbitrated normally from IDLE.

Test Plan:
1. Single ADD: iReq0=1, A0=0x05, B0=0x03, Mode0=0, iReady=1 -> oGnt0 pulse in cycle 1; cycle 2: oValid=1, oSum=0x08, oCarry=0, oId=0; oBusy low in cycle 3.
2. Carry/borrow:
   - 0xFF+0x01 ADD -> oSum=0x00, oCarry=1.
   - 0x03-0x05 SUB -> oSum=0xFE, oCarry=1.
   - 0x05-0x03 SUB -> oSum=0x02, oCarry=0.
   - 0x80-0x80 SUB -> oSum=0x00, oCarry=0.
3. Round-robin: both requests held high from reset (req0: 0x10+0x01, req1: 0x20-0x01) -> results in order oId=0 (0x11), 1 (0x1F), 0, 1; each oGnt is a single-cycle pulse, never both together.
4. Backpressure: iReady=0 for 5 cycles during RESP while iReq1 is high -> oValid, oSum, oCarry and oId stay constant and no oGnt1 fires. iReady=1 -> accepted, then oGnt1 fires one cycle after return to IDLE.
5. Operand hold: change iA0 from 0x05 to 0xAA the cycle after oGnt0 -> result still uses 0x05.
6. Reset mid-op: assert iRst for one cycle while in EXEC -> next cycle all outputs are 0 and state is IDLE, with no oValid for the aborted op. A held iReq0 is then granted normally.
